// File: rtl/byte_mem_responder.sv
// byte_mem_responder
//   Byte-wide memory that sits behind a multicycle CPU memory interface.
//   A request (memread/memwrite level) is latched in IDLE. The block then
//   spends WAIT_STATES cycles in WAIT and completes in DONE, where ready
//   pulses for one cycle and the access is applied to the array. A side
//   load port preloads bytes at any time.
//
// Ports
//   clk, reset          : single rising-edge clock, synchronous active-high reset
//   memread, memwrite   : request levels, held by the requester until ready
//   adr, writedata      : request address and store data (latched on acceptance)
//   memdata             : registered read data, updated only when a read completes
//   ready               : one-cycle completion pulse (high while in DONE)
//   load_we/adr/data    : preload write port
//
// Handshake: a request is accepted on the first rising edge in IDLE where
// memread|memwrite is high; ready is high during exactly one cycle,
// WAIT_STATES+1 cycles after acceptance. The requester drops its request in
// the ready cycle; a request still high in the following IDLE cycle starts a
// new access.
module byte_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic [7:0]            writedata,
  output logic [7:0]            memdata,
  output logic                  ready,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_adr,
  input  logic [7:0]            load_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int                  IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]          WS     = WAIT_STATES[3:0];
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic                    op_wr_q, op_wr_d;
  logic [7:0]              memdata_q, memdata_d;

  logic [7:0]              mem [DEPTH];

  logic                    adr_in_range;
  logic                    load_in_range;
  logic [IDX_W-1:0]        adr_idx;
  logic [IDX_W-1:0]        load_idx;
  logic [7:0]              rd_byte;

  assign adr_in_range  = ({1'b0, adr_q}    < DEPTH_L);
  assign load_in_range = ({1'b0, load_adr} < DEPTH_L);
  assign adr_idx       = adr_q[IDX_W-1:0];
  assign load_idx      = load_adr[IDX_W-1:0];

  // Out-of-range reads return zero instead of an aliased location.
  always_comb begin
    rd_byte = 8'h00;
    if (adr_in_range) rd_byte = mem[adr_idx];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    op_wr_d   = op_wr_q;
    memdata_d = memdata_q;
    case (state_q)
      S_IDLE: begin
        if (memread || memwrite) begin
          adr_d   = adr;
          wdata_d = writedata;
          // Both levels high counts as a write.
          op_wr_d = memwrite;
          if (WS == 4'd0) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = WS;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Request inputs are ignored here; the latched request completes.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        if (!op_wr_q) memdata_d = rd_byte;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      adr_q     <= '0;
      wdata_q   <= 8'h00;
      op_wr_q   <= 1'b0;
      memdata_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      op_wr_q   <= op_wr_d;
      memdata_q <= memdata_d;
    end
  end

  // Array is never cleared by reset. The DONE write is issued after the
  // load write so it wins on an address collision in the same cycle. A
  // reset in DONE aborts the store.
  always_ff @(posedge clk) begin
    if (load_we && load_in_range) mem[load_idx] <= load_data;
    if (!reset && (state_q == S_DONE) && op_wr_q && adr_in_range)
      mem[adr_idx] <= wdata_q;
  end

  assign ready   = (state_q == S_DONE);
  assign memdata = memdata_q;

endmodule

// File: tb/tb_byte_mem_responder.sv
// Directed bench for byte_mem_responder. Five instances cover the parameter
// sets exercised: 0: WS=2, 1: WS=0, 2: WS=1, 3: WS=1 DEPTH=128, 4: WS=3.
module tb_byte_mem_responder;

  localparam int N = 5;

  logic             clk;
  logic [N-1:0]     rst;
  logic [N-1:0]     memread;
  logic [N-1:0]     memwrite;
  logic [N-1:0]     ready;
  logic [N-1:0]     load_we;
  logic [7:0]       adr       [N];
  logic [7:0]       writedata [N];
  logic [7:0]       memdata   [N];
  logic [7:0]       load_adr  [N];
  logic [7:0]       load_data [N];

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- DUTs ----------------
  byte_mem_responder #(.ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(2)) u_dut0 (
    .clk(clk), .reset(rst[0]), .memread(memread[0]), .memwrite(memwrite[0]),
    .adr(adr[0]), .writedata(writedata[0]), .memdata(memdata[0]), .ready(ready[0]),
    .load_we(load_we[0]), .load_adr(load_adr[0]), .load_data(load_data[0]));
  byte_mem_responder #(.ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .reset(rst[1]), .memread(memread[1]), .memwrite(memwrite[1]),
    .adr(adr[1]), .writedata(writedata[1]), .memdata(memdata[1]), .ready(ready[1]),
    .load_we(load_we[1]), .load_adr(load_adr[1]), .load_data(load_data[1]));
  byte_mem_responder #(.ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(1)) u_dut2 (
    .clk(clk), .reset(rst[2]), .memread(memread[2]), .memwrite(memwrite[2]),
    .adr(adr[2]), .writedata(writedata[2]), .memdata(memdata[2]), .ready(ready[2]),
    .load_we(load_we[2]), .load_adr(load_adr[2]), .load_data(load_data[2]));
  byte_mem_responder #(.ADDR_WIDTH(8), .DEPTH(128), .WAIT_STATES(1)) u_dut3 (
    .clk(clk), .reset(rst[3]), .memread(memread[3]), .memwrite(memwrite[3]),
    .adr(adr[3]), .writedata(writedata[3]), .memdata(memdata[3]), .ready(ready[3]),
    .load_we(load_we[3]), .load_adr(load_adr[3]), .load_data(load_data[3]));
  byte_mem_responder #(.ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(3)) u_dut4 (
    .clk(clk), .reset(rst[4]), .memread(memread[4]), .memwrite(memwrite[4]),
    .adr(adr[4]), .writedata(writedata[4]), .memdata(memdata[4]), .ready(ready[4]),
    .load_we(load_we[4]), .load_adr(load_adr[4]), .load_data(load_data[4]));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_load(input int i, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_we[i]   = 1'b1;
    load_adr[i]  = a;
    load_data[i] = d;
    @(negedge clk);
    load_we[i]   = 1'b0;
  endtask

  // Issues one request, checks ready latency (cycles from the accepting
  // edge, counting that edge as 1) and that ready is a single-cycle pulse.
  task automatic do_req(input int i, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] wd,
                        input int exp_lat, input string tag);
    int cyc;
    @(negedge clk);
    memread[i]   = rd;
    memwrite[i]  = wr;
    adr[i]       = a;
    writedata[i] = wd;
    cyc = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready[i]) break;
    end
    check({tag, "_lat"}, cyc, exp_lat);
    @(negedge clk);
    memread[i]  = 1'b0;
    memwrite[i] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, ready[i]}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] fetch_exp [4];
    int cyc;
    int seen;
    n_checks = 0;
    n_fail   = 0;
    rst      = '1;
    memread  = '0;
    memwrite = '0;
    load_we  = '0;
    for (int i = 0; i < N; i++) begin
      adr[i] = 8'h00; writedata[i] = 8'h00; load_adr[i] = 8'h00; load_data[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_ready%0d", i), {31'd0, ready[i]}, 32'd0);
      check($sformatf("reset_memdata%0d", i), {24'd0, memdata[i]}, 32'h00);
    end
    @(negedge clk);
    rst = '0;

    // Fetch read with two wait states.
    do_load(0, 8'h04, 8'hA5);
    do_req(0, 1'b1, 1'b0, 8'h04, 8'h00, 3, "fetch_ws2");
    check("fetch_ws2_data", {24'd0, memdata[0]}, 32'hA5);

    // Conflict: both levels high is a write, memdata untouched.
    do_load(0, 8'h09, 8'h11);
    do_req(0, 1'b1, 1'b0, 8'h09, 8'h00, 3, "pre_conflict");
    check("pre_conflict_data", {24'd0, memdata[0]}, 32'h11);
    do_req(0, 1'b1, 1'b1, 8'h08, 8'hFF, 3, "conflict");
    check("conflict_memdata_held", {24'd0, memdata[0]}, 32'h11);
    do_req(0, 1'b1, 1'b0, 8'h08, 8'h00, 3, "conflict_rb");
    check("conflict_rb_data", {24'd0, memdata[0]}, 32'hFF);

    // Zero wait states: store then load.
    do_load(1, 8'h11, 8'h9E);
    do_req(1, 1'b1, 1'b0, 8'h11, 8'h00, 1, "ws0_rd");
    check("ws0_rd_data", {24'd0, memdata[1]}, 32'h9E);
    do_req(1, 1'b0, 1'b1, 8'h10, 8'h3C, 1, "ws0_wr");
    check("ws0_wr_memdata_held", {24'd0, memdata[1]}, 32'h9E);
    do_req(1, 1'b1, 1'b0, 8'h10, 8'h00, 1, "ws0_rd2");
    check("ws0_rd2_data", {24'd0, memdata[1]}, 32'h3C);

    // Four-byte fetch, request held continuously, address advanced in DONE.
    fetch_exp[0] = 8'h20; fetch_exp[1] = 8'h07; fetch_exp[2] = 8'h00; fetch_exp[3] = 8'h05;
    for (int k = 0; k < 4; k++) do_load(2, k[7:0], fetch_exp[k]);
    @(negedge clk);
    memread[2] = 1'b1;
    adr[2]     = 8'h00;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == 1 && k > 0)
          check($sformatf("fetch4_data%0d", k - 1), {24'd0, memdata[2]}, {24'd0, fetch_exp[k-1]});
        if (ready[2]) break;
      end
      check($sformatf("fetch4_spacing%0d", k), cyc, (k == 0) ? 2 : 3);
      @(negedge clk);
      if (k < 3) adr[2] = 8'(k + 1);
      else memread[2] = 1'b0;
    end
    @(posedge clk);
    #1;
    check("fetch4_data3", {24'd0, memdata[2]}, {24'd0, fetch_exp[3]});
    check("fetch4_no_extra", {31'd0, ready[2]}, 32'd0);

    // Out of range with DEPTH=128.
    do_load(3, 8'h05, 8'h6B);
    do_load(3, 8'h10, 8'h22);
    do_req(3, 1'b1, 1'b0, 8'h05, 8'h00, 2, "oor_pre");
    check("oor_pre_data", {24'd0, memdata[3]}, 32'h6B);
    do_req(3, 1'b0, 1'b1, 8'h90, 8'h55, 2, "oor_wr");
    do_req(3, 1'b1, 1'b0, 8'h90, 8'h00, 2, "oor_rd");
    check("oor_rd_data", {24'd0, memdata[3]}, 32'h00);
    do_req(3, 1'b1, 1'b0, 8'h10, 8'h00, 2, "oor_alias");
    check("oor_alias_data", {24'd0, memdata[3]}, 32'h22);

    // Reset during the second WAIT cycle of a write.
    do_load(4, 8'h20, 8'h01);
    do_load(4, 8'h21, 8'hC3);
    do_req(4, 1'b1, 1'b0, 8'h21, 8'h00, 4, "rst_pre");
    check("rst_pre_data", {24'd0, memdata[4]}, 32'hC3);
    @(negedge clk);
    memwrite[4]  = 1'b1;
    adr[4]       = 8'h20;
    writedata[4] = 8'h77;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[4]      = 1'b1;
    memwrite[4] = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready[4]}, 32'd0);
    check("rst_memdata", {24'd0, memdata[4]}, 32'h00);
    @(negedge clk);
    rst[4] = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ready[4]) seen++;
    end
    check("rst_no_ready", seen, 0);
    do_req(4, 1'b1, 1'b0, 8'h20, 8'h00, 4, "rst_post");
    check("rst_post_data", {24'd0, memdata[4]}, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
